// File: rtl/ir_nec_tx.sv
// ir_nec_tx -- NEC-format infrared transmitter.
//
// On an accepted START the module sends one frame carrying the 32-bit word
// {ADDR, ~ADDR, CMD, ~CMD}, MSB first. The frame has these parts:
//   - a 16-unit leader mark;
//   - an 8-unit leader space;
//   - 32 pulse-distance bits (1-unit mark, then a 1-unit space for 0 or a 3-unit space for 1);
//   - a 1-unit stop mark;
//   - GAP_UNITS idle units, during which BUSY is still held high.
//
// Build option: define IR_TX_CARRIER_EN to modulate IR_LED with a carrier
// during marks. IR_LED toggles every CARRIER_HALF cycles, and the carrier
// restarts at each mark. Without the macro, IR_LED is simply ~IR_LVL.
//
// Ports:
//   FPGA_CLK  in      system clock
//   FPGA_RST  in      asynchronous reset, active-low
//   START     in      one-cycle frame request, ignored while BUSY=1
//   ADDR      in [8]  address byte, captured on the accepted START
//   CMD       in [8]  command byte, captured on the accepted START
//   BUSY      out     high from the cycle after an accepted START to the end of the gap
//   DONE      out     one-cycle pulse on the last gap cycle
//   IR_LVL    out     line level: 0 = mark, 1 = space/idle
//   IR_LED    out     emitter drive, high (or carrier) during mark
//
// UNIT_CYC must be at least 2, because DONE is registered one cycle ahead.
module ir_nec_tx #(
  parameter int UNIT_CYC     = 28125,
  parameter int GAP_UNITS    = 72,
  parameter int CARRIER_HALF = 658
) (
  input  logic       FPGA_CLK,
  input  logic       FPGA_RST,
  input  logic       START,
  input  logic [7:0] ADDR,
  input  logic [7:0] CMD,
  output logic       BUSY,
  output logic       DONE,
  output logic       IR_LVL,
  output logic       IR_LED
);

  localparam int CW = (UNIT_CYC > 2) ? $clog2(UNIT_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] CYC_PRE  = CW'(UNIT_CYC - 2);
  localparam logic [6:0]    GAP_LAST = 7'(GAP_UNITS - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cyc_cnt;
  logic [6:0]    unit_cnt;
  logic [6:0]    unit_last;
  logic [5:0]    bit_cnt;
  logic [31:0]   sreg;
  logic          unit_tick;
  logic          state_end;
  logic          mark_next;

`ifdef IR_TX_CARRIER_EN
  localparam int KW = (CARRIER_HALF > 2) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [KW-1:0] CAR_LAST = KW'(CARRIER_HALF - 1);
  logic [KW-1:0] car_cnt;
`endif

  always_comb begin
    unit_tick = (cyc_cnt == CYC_LAST);
    unit_last = 7'd0;
    case (state)
      LEAD_MARK:  unit_last = 7'd15;
      LEAD_SPACE: unit_last = 7'd7;
      BIT_SPACE:  unit_last = sreg[31] ? 7'd2 : 7'd0;
      GAP:        unit_last = GAP_LAST;
      default:    unit_last = 7'd0;
    endcase
    state_end = unit_tick && (unit_cnt == unit_last);

    state_next = state;
    case (state)
      IDLE:       if (START)     state_next = LEAD_MARK;
      LEAD_MARK:  if (state_end) state_next = LEAD_SPACE;
      LEAD_SPACE: if (state_end) state_next = BIT_MARK;
      BIT_MARK:   if (state_end) state_next = BIT_SPACE;
      // bit_cnt still holds the pre-increment value here, so 31 means the last bit.
      BIT_SPACE:  if (state_end) state_next = (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (state_end) state_next = GAP;
      GAP:        if (state_end) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    mark_next = (state_next == LEAD_MARK) || (state_next == BIT_MARK) ||
                (state_next == STOP_MARK);
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      unit_cnt <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      IR_LVL   <= 1'b1;
      IR_LED   <= 1'b0;
`ifdef IR_TX_CARRIER_EN
      car_cnt  <= '0;
`endif
    end else begin
      // DONE is raised one cycle early so the registered pulse lands on the last gap cycle.
      DONE <= (state == GAP) && (unit_cnt == GAP_LAST) && (cyc_cnt == CYC_PRE);

      if (state_next != state) begin
        state    <= state_next;
        cyc_cnt  <= '0;
        unit_cnt <= '0;
        BUSY     <= (state_next != IDLE);
        IR_LVL   <= ~mark_next;
        // The carrier build also starts each mark with IR_LED high.
        IR_LED   <= mark_next;
`ifdef IR_TX_CARRIER_EN
        car_cnt  <= '0;
`endif
        if (state == IDLE) begin
          sreg    <= {ADDR, ~ADDR, CMD, ~CMD};
          bit_cnt <= '0;
        end
        if (state == BIT_SPACE) begin
          sreg    <= {sreg[30:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
        end
      end else if (state != IDLE) begin
        cyc_cnt <= unit_tick ? '0 : cyc_cnt + CW'(1);
        if (unit_tick) unit_cnt <= unit_cnt + 7'd1;
`ifdef IR_TX_CARRIER_EN
        if (!IR_LVL) begin
          if (car_cnt == CAR_LAST) begin
            car_cnt <= '0;
            IR_LED  <= ~IR_LED;
          end else begin
            car_cnt <= car_cnt + KW'(1);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
module tb_ir_nec_tx;
  localparam int U   = 4;
  localparam int GAP = 72;
  localparam int CH  = 3;
`ifdef IR_TX_CARRIER_EN
  localparam bit CARRIER = 1'b1;
`else
  localparam bit CARRIER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] cmd = 8'h00;
  logic       busy, done, lvl, led;

  int n_cmp = 0;
  int n_err = 0;

  logic exp_lvl[$];
  logic exp_led[$];
  logic obs_lvl[$];

  always #5 clk = ~clk;

  ir_nec_tx #(.UNIT_CYC(U), .GAP_UNITS(GAP), .CARRIER_HALF(CH)) dut (
    .FPGA_CLK(clk), .FPGA_RST(rst_n), .START(start), .ADDR(addr), .CMD(cmd),
    .BUSY(busy), .DONE(done), .IR_LVL(lvl), .IR_LED(led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One line segment of the reference waveform: mark (low) or space (high) for some units.
  task automatic add_seg(input bit mark, input int units);
    for (int p = 0; p < units * U; p++) begin
      exp_lvl.push_back(!mark);
      if (!mark)        exp_led.push_back(1'b0);
      else if (CARRIER) exp_led.push_back(((p / CH) % 2) == 0);
      else              exp_led.push_back(1'b1);
    end
  endtask

  task automatic build_frame(input logic [31:0] word);
    exp_lvl.delete();
    exp_led.delete();
    add_seg(1, 16);
    add_seg(0, 8);
    for (int b = 31; b >= 0; b--) begin
      add_seg(1, 1);
      add_seg(0, word[b] ? 3 : 1);
    end
    add_seg(1, 1);
    add_seg(0, GAP);
  endtask

  // Independent receiver: rebuild the word from observed space lengths.
  task automatic decode(input logic [31:0] word, input string tag);
    int run_len[$];
    logic [31:0] rx;
    int len;
    len = 1;
    for (int i = 1; i < obs_lvl.size(); i++) begin
      if (obs_lvl[i] == obs_lvl[i-1]) len++;
      else begin
        run_len.push_back(len);
        len = 1;
      end
    end
    run_len.push_back(len);
    check({tag, "_runs"}, run_len.size(), 68);
    rx = '0;
    if (run_len.size() >= 67)
      for (int b = 0; b < 32; b++) rx = {rx[30:0], run_len[3 + 2*b] > 2*U};
    check({tag, "_rxword"}, rx, word);
    check({tag, "_rxcmd"}, {24'd0, rx[15:8]}, {24'd0, word[15:8]});
    $display("frame %s: sent %h received %h", tag, word, rx);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input int inject_at,
                           input string tag);
    logic [31:0] word;
    int n;
    int last_low;
    word = {a, ~a, c, ~c};
    build_frame(word);
    n = exp_lvl.size();
    obs_lvl.delete();
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    cmd   = c;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        addr  = 8'($urandom);
        cmd   = 8'($urandom);
      end
      if (i == inject_at) begin
        start = 1'b1;
        cmd   = 8'h30;
      end
      if (i == inject_at + 1) start = 1'b0;
      check({tag, "_lvl"}, lvl, exp_lvl[i]);
      check({tag, "_led"}, led, exp_led[i]);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_done"}, done, (i == n - 1));
      obs_lvl.push_back(lvl);
    end
    @(negedge clk);
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_lvl"}, lvl, 1'b1);
    check({tag, "_end_done"}, done, 1'b0);
    last_low = 0;
    for (int i = 0; i < obs_lvl.size(); i++) if (!obs_lvl[i]) last_low = i + 1;
    check({tag, "_frame_len"}, last_low, (24 + 64 + 2 * $countones(word) + 1) * U);
    decode(word, tag);
  endtask

  initial begin
    int bit10;
    logic [31:0] w;

    // Reset held with START asserted, then released.
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_lvl", lvl, 1'b1);
    check("rst_led", led, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_lvl", lvl, 1'b1);
    end

    // Reference frame 0x00FF6897: 121 frame units, DONE on cycle 193*U after BUSY rises.
    run_frame(8'h00, 8'h68, -10, "f68");
    check("f68_total", exp_lvl.size(), 193 * U);

    // Second START mid-frame must be ignored.
    run_frame(8'h00, 8'h68, 40 * U, "f68_inject");

    // Random frames.
    for (int k = 0; k < 3; k++)
      run_frame(8'($urandom), 8'($urandom), (k == 1) ? 100 * U : -10, $sformatf("rnd%0d", k));

    // Reset during bit 10.
    w = {8'h00, 8'hFF, 8'h68, 8'h97};
    bit10 = 24 * U;
    for (int b = 31; b > 21; b--) bit10 += (w[b] ? 4 : 2) * U;
    @(negedge clk);
    start = 1'b1;
    addr  = 8'h00;
    cmd   = 8'h68;
    @(negedge clk);
    start = 1'b0;
    repeat (bit10) @(negedge clk);
    check("pre_abort_lvl", lvl, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_lvl", lvl, 1'b1);
    check("abort_led", led, 1'b0);
    check("abort_busy", busy, 1'b0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("abort_done", done, 1'b0);
      check("abort_idle", lvl, 1'b1);
    end

    run_frame(8'h00, 8'h68, -10, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
